// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM channel arbiter: FSM states, requester count and
// the per-requester request slot.
package sdram_arb_pkg;

  localparam int NUM_REQ  = 3;
  // Slots store addresses at a fixed maximum width; the top trims to ADDR_W.
  localparam int ADDR_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic                rnw;
    logic [ADDR_MAX-1:0] addr;
    logic [31:0]         din;
    logic [3:0]          be;
  } slot_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection: the lowest-index starved slot (age at AGE_MAX) first,
// otherwise round-robin starting after the last served requester.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int AGE_MAX = 7,
  parameter int AGE_W   = 3
) (
  input  logic [NUM_REQ-1:0]            pending,
  input  logic [NUM_REQ-1:0][AGE_W-1:0] age,
  input  logic [1:0]                    last_grant,
  output logic                          any,
  output logic [1:0]                    win
);

  always_comb begin
    int   idx;
    logic found;
    found = 1'b0;
    win   = 2'd0;
    idx   = 0;
    any   = |pending;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pending[i] && age[i] == AGE_W'(AGE_MAX)) begin
        found = 1'b1;
        win   = 2'(i);
      end
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// Three-requester arbiter in front of one SDRAM controller channel: request
// slots, age/round-robin grant, single outstanding access with timeout.
module sdram_ch_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int AGE_MAX = 7,
  parameter int TMO_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        rq_req,
  input  logic [NUM_REQ-1:0]        rq_rnw,
  input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
  input  logic [NUM_REQ*32-1:0]     rq_din,
  input  logic [NUM_REQ*4-1:0]      rq_be,
  output logic [NUM_REQ-1:0]        rq_ready,
  output logic [31:0]               rq_dout,
  output logic                      mem_req,
  output logic                      mem_rnw,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_din,
  output logic [3:0]                mem_be,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_dout,
  output logic                      busy,
  output logic                      err_ovf,
  output logic                      err_tmo
);

  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam int CNT_W = $clog2(TMO_CYC + 1);

  state_e                        state, state_nxt;
  slot_t  [NUM_REQ-1:0]          slot;
  slot_t                         gslot, wslot;
  logic   [NUM_REQ-1:0]          pending, accept;
  logic   [NUM_REQ-1:0][AGE_W-1:0] age;
  logic   [1:0]                  grant, last_grant, win;
  logic                          any, done_ok, tmo_hit, done;
  logic   [CNT_W-1:0]            cnt;
  logic                          unused_bits;

  assign gslot = slot[grant];
  assign wslot = slot[win];
  assign unused_bits = ^{gslot, wslot};

  // The counter is 0 during ISSUE, so expiry fires TMO_CYC cycles after mem_req.
  assign done_ok = (state == S_WAIT) && mem_ready;
  assign tmo_hit = (state == S_WAIT) && !mem_ready && (cnt == CNT_W'(TMO_CYC - 1));
  assign done    = done_ok || tmo_hit;
  assign busy    = (|pending) || (state != S_IDLE);

  // A slot completing this cycle may be refilled in the same cycle.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_REQ; i++)
      accept[i] = rq_req[i] && (!pending[i] || (done && grant == 2'(i)));
  end

  sdram_arb_pick #(.AGE_MAX(AGE_MAX), .AGE_W(AGE_W)) u_pick (
    .pending    (pending),
    .age        (age),
    .last_grant (last_grant),
    .any        (any),
    .win        (win)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot    <= '0;
      pending <= '0;
      age     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i])
          slot[i] <= '{rnw:  rq_rnw[i],
                       addr: ADDR_MAX'(rq_addr[i*ADDR_W +: ADDR_W]),
                       din:  rq_din[i*32 +: 32],
                       be:   rq_be[i*4 +: 4]};
        if (accept[i])                        pending[i] <= 1'b1;
        else if (done && grant == 2'(i))      pending[i] <= 1'b0;
        if (done) begin
          if (grant == 2'(i))                 age[i] <= '0;
          else if (!pending[i])               age[i] <= '0;
          else if (age[i] != AGE_W'(AGE_MAX)) age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= 2'd0;
      last_grant <= 2'd2;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_rnw    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_be     <= '0;
      rq_ready   <= '0;
      rq_dout    <= '0;
      err_ovf    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      rq_ready <= '0;
      if (|(rq_req & ~accept)) err_ovf <= 1'b1;
      if (state == S_IDLE && any) begin
        grant    <= win;
        mem_req  <= 1'b1;
        mem_rnw  <= wslot.rnw;
        mem_addr <= wslot.addr[ADDR_W-1:0];
        mem_din  <= wslot.din;
        mem_be   <= wslot.be;
        cnt      <= '0;
      end else if (state != S_IDLE && !done) begin
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        rq_ready[grant] <= 1'b1;
        rq_dout         <= (done_ok && gslot.rnw) ? mem_dout : 32'd0;
        last_grant      <= grant;
        if (tmo_hit) err_tmo <= 1'b1;
      end
    end
  end

endmodule
